// File: rtl/par_to_ser_8bits.sv
// Parallel-to-serial converter: shifts one byte per 8 bit clocks out MSB first,
// sending an alignment run of IDLE_CHAR after reset and IDLE_CHAR in empty slots.
module par_to_ser_8bits #(
  parameter logic [7:0]  IDLE_CHAR   = 8'hBC,
  parameter int unsigned ALIGN_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       byte_tick,
  output logic       serial_out,
  output logic       active
);

  typedef enum logic {
    ALIGN  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [3:0] ALIGN_LAST = 4'(ALIGN_COUNT - 32'd1);

  state_t     state_r, state_nxt_s;
  logic [2:0] bit_cnt_r;
  logic [7:0] sr_r, sr_nxt_s;
  logic       serial_r, serial_nxt_s;
  logic [3:0] align_cnt_r, align_cnt_nxt_s;
  logic       active_r, active_nxt_s;
  logic       load_s;
  logic [7:0] sel_s;

  assign load_s     = (bit_cnt_r == 3'd0);
  assign byte_tick  = load_s & ~reset;
  assign serial_out = serial_r;
  assign active     = active_r;

  // Next-state, byte selection and shift datapath.
  always_comb begin
    sel_s           = IDLE_CHAR;
    state_nxt_s     = state_r;
    align_cnt_nxt_s = align_cnt_r;
    active_nxt_s    = active_r;
    case (state_r)
      ALIGN: begin
        if (load_s) begin
          align_cnt_nxt_s = align_cnt_r + 4'd1;
          if (align_cnt_r == ALIGN_LAST) begin
            state_nxt_s  = ACTIVE;
            active_nxt_s = 1'b1;
          end else begin
            state_nxt_s  = ALIGN;
          end
        end else begin
          align_cnt_nxt_s = align_cnt_r;
        end
      end
      ACTIVE: begin
        if (in_valid) begin
          sel_s = in_data;
        end else begin
          sel_s = IDLE_CHAR;
        end
      end
      default: begin
        state_nxt_s = ALIGN;
      end
    endcase
    // Load edge emits the MSB immediately and queues the remaining 7 bits.
    if (load_s) begin
      serial_nxt_s = sel_s[7];
      sr_nxt_s     = {sel_s[6:0], 1'b0};
    end else begin
      serial_nxt_s = sr_r[7];
      sr_nxt_s     = {sr_r[6:0], 1'b0};
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ALIGN;
      bit_cnt_r   <= 3'd0;
      sr_r        <= 8'h00;
      serial_r    <= 1'b0;
      align_cnt_r <= 4'd0;
      active_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      bit_cnt_r   <= bit_cnt_r + 3'd1;
      sr_r        <= sr_nxt_s;
      serial_r    <= serial_nxt_s;
      align_cnt_r <= align_cnt_nxt_s;
      active_r    <= active_nxt_s;
    end
  end

endmodule

// File: tb/tb_par_to_ser_8bits.sv
// Self-checking bench for par_to_ser_8bits: two instances (default and
// ALIGN_COUNT=1/IDLE_CHAR=7C) compared against a slot-level reference model.
module tb_par_to_ser_8bits;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic [1:0] bt, so, ac;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, per instance.
  int         ac_cfg[2]   = '{4, 1};
  logic [7:0] idle_cfg[2] = '{8'hBC, 8'h7C};
  int         t_m[2];
  int         loads_m[2];
  logic [7:0] cur_m[2];

  always #5 clk = ~clk;

  par_to_ser_8bits u_dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .byte_tick(bt[0]), .serial_out(so[0]), .active(ac[0])
  );

  par_to_ser_8bits #(.IDLE_CHAR(8'h7C), .ALIGN_COUNT(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .byte_tick(bt[1]), .serial_out(so[1]), .active(ac[1])
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  // One clock: drive inputs, check byte_tick before the edge, then update model and check outputs.
  task automatic step(input logic rst, input logic v, input logic [7:0] d);
    int ph;
    logic exp_so;
    @(negedge clk);
    reset = rst; in_valid = v; in_data = d;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("byte_tick%0d", i), {7'd0, bt[i]},
            {7'd0, (!rst && (t_m[i] % 8 == 0))});
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        t_m[i] = 0; loads_m[i] = 0; cur_m[i] = 8'h00;
        exp_so = 1'b0;
      end else begin
        ph = t_m[i] % 8;
        if (ph == 0) begin
          cur_m[i] = (loads_m[i] >= ac_cfg[i] && v) ? d : idle_cfg[i];
          loads_m[i]++;
        end
        exp_so = cur_m[i][7 - ph];
        t_m[i]++;
      end
      check($sformatf("serial_out%0d", i), {7'd0, so[i]}, {7'd0, exp_so});
      check($sformatf("active%0d", i), {7'd0, ac[i]},
            {7'd0, (!rst && loads_m[i] >= ac_cfg[i])});
    end
  endtask

  // Offer one byte at the load slot; non-load cycles carry junk that must be ignored.
  task automatic send_byte(input logic v, input logic [7:0] d);
    step(1'b0, v, d);
    for (int k = 1; k < 8; k++)
      step(1'b0, 1'($urandom_range(1)), 8'($urandom));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 8'h00);
    // Idle for 64 clocks: alignment run then idle fill.
    for (int b = 0; b < 8; b++) send_byte(1'b0, 8'h00);
    send_byte(1'b1, 8'hA5);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'hFF);
    send_byte(1'b1, 8'h81);
    // Reset again and offer 3C every other slot, including during alignment.
    step(1'b1, 1'b0, 8'h00);
    for (int b = 0; b < 12; b++) send_byte(b % 2 == 0, 8'h3C);
    // Mid-byte reset at bit_cnt=4 of a data byte.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'h5A);
    step(1'b1, 1'b1, 8'h5A);
    for (int b = 0; b < 8; b++) send_byte(1'b1, 8'hE7);
    // Random traffic.
    for (int b = 0; b < 150; b++) send_byte(1'($urandom_range(1)), 8'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
